vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 90 +++++++++
 tb/tb_vga_sync_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator: pixel divider, h/v counters, registered syncs
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_MAX      = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_MAX      = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_DISP_C   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_C   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_count_q, h_count_d;
    logic [9:0]       v_count_q, v_count_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             h_end, v_end;

    // Next-state counters; syncs decode the next count so they line up with the counter outputs
    always_comb begin
        p_tick    = (div_q == DIV_MAX);
        h_end     = (h_count_q == H_MAX);
        v_end     = (v_count_q == V_MAX);
        div_d     = p_tick ? '0 : div_q + 1'b1;
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (p_tick) begin
            if (h_end) begin
                h_count_d = '0;
                v_count_d = v_end ? '0 : v_count_q + 10'd1;
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
        end
        hsync_d = !((h_count_d >= HS_FIRST) && (h_count_d <= HS_LAST));
        vsync_d = !((v_count_d >= VS_FIRST) && (v_count_d <= VS_LAST));
    end

    // State registers; reset parks everything at the top-left pixel with syncs inactive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            h_count_q <= '0;
            v_count_q <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            div_q     <= div_d;
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    // Output decode straight from the registers
    always_comb begin
        pixel_x    = h_count_q;
        pixel_y    = v_count_q;
        hsync      = hsync_q;
        vsync      = vsync_q;
        video_on   = (h_count_q < H_DISP_C) && (v_count_q < V_DISP_C);
        frame_tick = p_tick && h_end && v_end;
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed-vector bench for vga_sync_gen (default and reduced timing)
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset_a = 1'b1;
    logic       reset_b = 1'b1;

    logic       hs_a, vs_a, vo_a, pt_a, ft_a;
    logic [9:0] px_a, py_a;
    logic       hs_b, vs_b, vo_b, pt_b, ft_b;
    logic [9:0] px_b, py_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut_a (
        .clk(clk), .reset(reset_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
        .p_tick(pt_a), .pixel_x(px_a), .pixel_y(py_a), .frame_tick(ft_a)
    );

    // Reduced timing: H 8/2/3/2 = 15 pixels, V 6/2/2/3 = 13 lines, 2 clk per pixel, 390 clk per frame
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_b (
        .clk(clk), .reset(reset_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
        .p_tick(pt_b), .pixel_x(px_b), .pixel_y(py_b), .frame_tick(ft_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_pixels_a(input int n);
        repeat (n * 4) tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++;
        if ({px_a, py_a, hs_a, vs_a, pt_a, ft_a, vo_a} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_a: got x=%0d y=%0d hs=%b vs=%b pt=%b ft=%b vo=%b, want 0 0 1 1 0 0 1",
                     px_a, py_a, hs_a, vs_a, pt_a, ft_a, vo_a);
        end
        vectors++;
        if ({px_b, py_b, hs_b, vs_b, pt_b, ft_b, vo_b} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_b: got x=%0d y=%0d hs=%b vs=%b pt=%b ft=%b vo=%b, want 0 0 1 1 0 0 1",
                     px_b, py_b, hs_b, vs_b, pt_b, ft_b, vo_b);
        end
    endtask

    task automatic test_first_tick();
        reset_a = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            vectors++;
            if (pt_a !== (e == 3) || px_a !== 10'd0) begin
                miscompares++;
                $display("FAIL first_tick edge%0d: got pt=%b x=%0d, want pt=%b x=0", e, pt_a, px_a, e == 3);
            end
        end
        tick();
        vectors++;
        if (pt_a !== 1'b0 || px_a !== 10'd1 || py_a !== 10'd0) begin
            miscompares++;
            $display("FAIL first_tick edge4: got pt=%b x=%0d y=%0d, want 0 1 0", pt_a, px_a, py_a);
        end
    endtask

    task automatic test_hsync();
        step_pixels_a(638);
        for (int x = 639; x <= 799; x++) begin
            vectors++;
            if (px_a !== 10'(x) || hs_a !== !(x >= 656 && x <= 751) || vo_a !== (x < 640) || vs_a !== 1'b1) begin
                miscompares++;
                $display("FAIL hsync x=%0d: got x=%0d hs=%b vo=%b vs=%b, want hs=%b vo=%b vs=1",
                         x, px_a, hs_a, vo_a, vs_a, !(x >= 656 && x <= 751), x < 640);
            end
            step_pixels_a(1);
        end
        vectors++;
        if (px_a !== 10'd0 || py_a !== 10'd1 || hs_a !== 1'b1 || vo_a !== 1'b1) begin
            miscompares++;
            $display("FAIL hsync_wrap: got x=%0d y=%0d hs=%b vo=%b, want 0 1 1 1", px_a, py_a, hs_a, vo_a);
        end
    endtask

    task automatic test_row_wrap();
        int n;
        repeat (3) tick();
        vectors++;
        if (px_a !== 10'd0 || pt_a !== 1'b1) begin
            miscompares++;
            $display("FAIL hold: got x=%0d pt=%b, want x=0 pt=1", px_a, pt_a);
        end
        tick();
        step_pixels_a(9 * 800 + 798);
        repeat (3) tick();
        vectors++;
        if (px_a !== 10'd799 || py_a !== 10'd10 || pt_a !== 1'b1 || ft_a !== 1'b0) begin
            miscompares++;
            $display("FAIL row10_end: got x=%0d y=%0d pt=%b ft=%b, want 799 10 1 0", px_a, py_a, pt_a, ft_a);
        end
        tick();
        vectors++;
        if (px_a !== 10'd0 || py_a !== 10'd11) begin
            miscompares++;
            $display("FAIL row_wrap: got x=%0d y=%0d, want 0 11", px_a, py_a);
        end
        n = 0;
        while (py_a !== 10'd12 && n < 4000) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 3200) begin
            miscompares++;
            $display("FAIL row_length: got %0d clk, want 3200", n);
        end
    endtask

    task automatic test_frame();
        int ft_count, ft_at, hs_low, vs_lines, first_vs_y, n;
        ft_count = 0; ft_at = -1; hs_low = 0; vs_lines = 0; first_vs_y = -1;
        reset_b = 1'b0;
        for (int k = 0; k < 390; k++) begin
            if (ft_b === 1'b1) begin
                ft_count++;
                ft_at = k;
                vectors++;
                if (px_b !== 10'd14 || py_b !== 10'd12 || pt_b !== 1'b1) begin
                    miscompares++;
                    $display("FAIL frame_tick_pos: got x=%0d y=%0d pt=%b, want 14 12 1", px_b, py_b, pt_b);
                end
            end
            if (hs_b === 1'b0) hs_low++;
            if (vs_b === 1'b0 && px_b == 10'd0 && pt_b === 1'b1) begin
                vs_lines++;
                if (first_vs_y < 0) first_vs_y = int'(py_b);
            end
            tick();
        end
        vectors++;
        if (ft_count != 1 || ft_at != 389) begin
            miscompares++;
            $display("FAIL frame_tick_count: got %0d at clk %0d, want 1 at 389", ft_count, ft_at);
        end
        vectors++;
        if (vs_lines != 2 || first_vs_y != 8) begin
            miscompares++;
            $display("FAIL vsync_lines: got %0d from y=%0d, want 2 from y=8", vs_lines, first_vs_y);
        end
        vectors++;
        if (hs_low != 78) begin
            miscompares++;
            $display("FAIL hsync_low_cycles: got %0d, want 78", hs_low);
        end
        vectors++;
        if (px_b !== 10'd0 || py_b !== 10'd0 || ft_b !== 1'b0 || vs_b !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_wrap: got x=%0d y=%0d ft=%b vs=%b, want 0 0 0 1", px_b, py_b, ft_b, vs_b);
        end
        n = 1;
        tick();
        while (ft_b !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (n != 389 || ft_b !== 1'b0 || px_b !== 10'd0 || py_b !== 10'd0) begin
            miscompares++;
            $display("FAIL frame_period: got ft at clk %0d then ft=%b x=%0d y=%0d, want 389 then 0 0 0",
                     n, ft_b, px_b, py_b);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (!(px_b == 10'd11 && py_b == 10'd8) && n < 500) begin
            tick();
            n++;
        end
        vectors++;
        if (hs_b !== 1'b0 || vs_b !== 1'b0 || vo_b !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset x=11 y=8 (reached=%0d): got hs=%b vs=%b vo=%b, want 0 0 0",
                     n < 500, hs_b, vs_b, vo_b);
        end
        #2;
        reset_b = 1'b1;
        #1;
        vectors++;
        if ({px_b, py_b, hs_b, vs_b, pt_b, ft_b, vo_b} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got x=%0d y=%0d hs=%b vs=%b pt=%b ft=%b vo=%b, want 0 0 1 1 0 0 1",
                     px_b, py_b, hs_b, vs_b, pt_b, ft_b, vo_b);
        end
        tick();
        tick();
        reset_b = 1'b0;
        tick();
        vectors++;
        if (pt_b !== 1'b1 || px_b !== 10'd0) begin
            miscompares++;
            $display("FAIL resume_edge1: got pt=%b x=%0d, want 1 0", pt_b, px_b);
        end
        tick();
        vectors++;
        if (pt_b !== 1'b0 || px_b !== 10'd1 || py_b !== 10'd0) begin
            miscompares++;
            $display("FAIL resume_edge2: got pt=%b x=%0d y=%0d, want 0 1 0", pt_b, px_b, py_b);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_hsync();
        test_row_wrap();
        test_frame();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
